// File: rtl/tt_um_jimktrains_vslc_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tt_um_jimktrains_vslc_fetch
// Description : Program store and scan sequencer feeding the VSLC executor.
//               Holds a byte-wide program loaded over a strobe interface and
//               replays it one byte per clock as a repeating PLC-style scan.
//               It also provides the per-scan input snapshot and a
//               free-running 16-bit cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_um_jimktrains_vslc_fetch #(
    parameter int PROG_DEPTH = 32,
    parameter int ADDR_W     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_mode,
    input  logic [7:0]        load_data,
    input  logic              load_strobe,
    input  logic              run_en,
    input  logic [7:0]        ui_in,
    output logic [7:0]        instr,
    output logic              instr_ready,
    output logic [7:0]        ui_scan,
    output logic [7:0]        ui_in_prev,
    output logic [15:0]       counter,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W:0]   prog_len,
    output logic              scan_start,
    output logic              load_overflow
);

    // Stack-class no-op presented whenever no instruction is valid.
    localparam logic [7:0]        c_NOP      = 8'hF4;
    localparam logic [ADDR_W:0]   c_FULL     = (ADDR_W + 1)'(PROG_DEPTH);
    localparam logic [ADDR_W:0]   c_LEN_ZERO = '0;
    localparam logic [ADDR_W:0]   c_LEN_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] c_PC_ZERO  = '0;
    localparam logic [ADDR_W-1:0] c_PC_ONE   = ADDR_W'(1);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_LOAD     = 2'd1;
    localparam logic [1:0] c_ST_RUN      = 2'd2;
    localparam logic [1:0] c_ST_SCAN_END = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;

    logic [7:0]        r_mem [PROG_DEPTH];
    logic [7:0]        r_instr;
    logic              r_instr_ready;
    logic [7:0]        r_ui_scan;
    logic [7:0]        r_ui_in_prev;
    logic [15:0]       r_counter;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W:0]   r_prog_len;
    logic              r_scan_start;
    logic              r_load_overflow;
    logic              r_strobe_prev;

    logic              w_entry;
    logic              w_strobe_rise;
    logic              w_full;
    logic              w_last;
    logic              w_write;

    // Entering programming mode from any other state only clears; writes
    // are accepted from the following cycle onwards.
    assign w_entry       = load_mode && (r_state != c_ST_LOAD);
    assign w_strobe_rise = load_strobe && !r_strobe_prev;
    assign w_full        = (r_prog_len == c_FULL);
    // prog_len is never zero while in RUN, so the subtraction cannot wrap
    // there; outside RUN this flag is ignored.
    assign w_last        = ({1'b0, r_pc} == (r_prog_len - c_LEN_ONE));
    assign w_write       = (r_state == c_ST_LOAD) && load_mode &&
                           w_strobe_rise && !w_full;

    assign instr         = r_instr;
    assign instr_ready   = r_instr_ready;
    assign ui_scan       = r_ui_scan;
    assign ui_in_prev    = r_ui_in_prev;
    assign counter       = r_counter;
    assign pc            = r_pc;
    assign prog_len      = r_prog_len;
    assign scan_start    = r_scan_start;
    assign load_overflow = r_load_overflow;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: load_mode overrides every state, otherwise the
    // scan alternates RUN bytes with a single SCAN_END cycle.
    always_comb begin
        w_state_next = r_state;
        if (w_entry) begin
            w_state_next = c_ST_LOAD;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    w_state_next = c_ST_IDLE;
                end
                c_ST_LOAD: begin
                    if (!load_mode) begin
                        w_state_next = (r_prog_len == c_LEN_ZERO) ? c_ST_IDLE
                                                                  : c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    if (run_en && w_last) begin
                        w_state_next = c_ST_SCAN_END;
                    end
                end
                c_ST_SCAN_END: begin
                    w_state_next = c_ST_RUN;
                end
                default: begin
                    w_state_next = c_ST_IDLE;
                end
            endcase
        end
    end

    // Program store write port; contents survive reset on purpose, an empty
    // prog_len makes them unreachable.
    always_ff @(posedge clk) begin
        if (rst_n && w_write) begin
            r_mem[r_prog_len[ADDR_W-1:0]] <= load_data;
        end
    end

    // Registered datapath: counter, strobe edge detect, load bookkeeping,
    // fetch outputs and the per-scan input snapshot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_counter       <= 16'd0;
            r_strobe_prev   <= 1'b0;
            r_instr         <= c_NOP;
            r_instr_ready   <= 1'b0;
            r_scan_start    <= 1'b0;
            r_ui_scan       <= 8'd0;
            r_ui_in_prev    <= 8'd0;
            r_pc            <= c_PC_ZERO;
            r_prog_len      <= c_LEN_ZERO;
            r_load_overflow <= 1'b0;
        end else begin
            r_counter     <= r_counter + 16'd1;
            r_strobe_prev <= load_strobe;
            // Fetch outputs default to "nothing valid" every cycle.
            r_instr       <= c_NOP;
            r_instr_ready <= 1'b0;
            r_scan_start  <= 1'b0;

            if (w_entry) begin
                r_pc            <= c_PC_ZERO;
                r_prog_len      <= c_LEN_ZERO;
                r_load_overflow <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_LOAD: begin
                        if (load_mode) begin
                            if (w_strobe_rise) begin
                                if (w_full) begin
                                    r_load_overflow <= 1'b1;
                                end else begin
                                    r_prog_len <= r_prog_len + c_LEN_ONE;
                                end
                            end
                        end else if (r_prog_len != c_LEN_ZERO) begin
                            // Seed both snapshots identically so the first
                            // scan sees no spurious input edges.
                            r_pc         <= c_PC_ZERO;
                            r_ui_scan    <= ui_in;
                            r_ui_in_prev <= ui_in;
                        end
                    end
                    c_ST_RUN: begin
                        if (run_en) begin
                            r_instr       <= r_mem[r_pc];
                            r_instr_ready <= 1'b1;
                            r_scan_start  <= (r_pc == c_PC_ZERO);
                            r_pc          <= w_last ? c_PC_ZERO : (r_pc + c_PC_ONE);
                        end
                    end
                    c_ST_SCAN_END: begin
                        r_ui_in_prev <= r_ui_scan;
                        r_ui_scan    <= ui_in;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tt_um_jimktrains_vslc_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_um_jimktrains_vslc_fetch
// Description : Self-checking bench for the VSLC fetch block. Stimulus pushes
//               the expected instruction stream into a scoreboard queue; a
//               negedge monitor pops and compares on every instr_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_um_jimktrains_vslc_fetch;

    localparam int PROG_DEPTH = 32;
    localparam int ADDR_W     = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_mode;
    logic [7:0]        load_data;
    logic              load_strobe;
    logic              run_en;
    logic [7:0]        ui_in;
    logic [7:0]        instr;
    logic              instr_ready;
    logic [7:0]        ui_scan;
    logic [7:0]        ui_in_prev;
    logic [15:0]       counter;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W:0]   prog_len;
    logic              scan_start;
    logic              load_overflow;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // {scan_start, instr} expected for each instr_ready cycle
    logic [8:0] exp_q [$];
    int         ss_cyc [$];

    tt_um_jimktrains_vslc_fetch #(
        .PROG_DEPTH (PROG_DEPTH),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_mode     (load_mode),
        .load_data     (load_data),
        .load_strobe   (load_strobe),
        .run_en        (run_en),
        .ui_in         (ui_in),
        .instr         (instr),
        .instr_ready   (instr_ready),
        .ui_scan       (ui_scan),
        .ui_in_prev    (ui_in_prev),
        .counter       (counter),
        .pc            (pc),
        .prog_len      (prog_len),
        .scan_start    (scan_start),
        .load_overflow (load_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load_byte(input logic [7:0] b);
        load_data   = b;
        load_strobe = 1'b1;
        @(negedge clk);
        load_strobe = 1'b0;
        @(negedge clk);
    endtask

    task automatic push_byte(input logic ss, input logic [7:0] b);
        exp_q.push_back({ss, b});
    endtask

    // Monitor: compares every presented instruction against the scoreboard.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n === 1'b1) begin
            checks++;
            if (instr_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_instr: got %02h ss=%0b, none expected (t=%0t)",
                             instr, scan_start, $time);
                end else begin
                    e = exp_q.pop_front();
                    if ({scan_start, instr} !== e) begin
                        errors++;
                        $display("FAIL instr_stream: got ss=%0b instr=%02h expected ss=%0b instr=%02h (t=%0t)",
                                 scan_start, instr, e[8], e[7:0], $time);
                    end
                end
                if (scan_start === 1'b1) ss_cyc.push_back(cyc);
            end else if (instr !== 8'hF4 || scan_start !== 1'b0 || instr_ready !== 1'b0) begin
                errors++;
                $display("FAIL idle_outputs: got ready=%0b instr=%02h ss=%0b expected 0/F4/0 (t=%0t)",
                         instr_ready, instr, scan_start, $time);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] prev_cnt;
        logic        wrap_seen;
        rst_n = 1'b0; load_mode = 1'b0; load_strobe = 1'b0;
        load_data = 8'h00; run_en = 1'b0; ui_in = 8'h00;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_instr", instr, 8'hF4);
        chk("rst_ready", instr_ready, 0);
        chk("rst_ui_scan", ui_scan, 0);
        chk("rst_ui_prev", ui_in_prev, 0);
        chk("rst_counter", counter, 0);
        chk("rst_pc", pc, 0);
        chk("rst_prog_len", prog_len, 0);
        chk("rst_scan_start", scan_start, 0);
        chk("rst_overflow", load_overflow, 0);

        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_counter", counter, 20);
        chk("idle_ready", instr_ready, 0);
        chk("idle_prog_len", prog_len, 0);

        // Three-byte program, three full scans, input snapshot tracking
        load_mode = 1'b1;
        @(negedge clk);
        load_byte(8'h00); load_byte(8'h48); load_byte(8'h81);
        chk("prog_len_3", prog_len, 3);
        for (int s = 0; s < 3; s++) begin
            push_byte(1'b1, 8'h00); push_byte(1'b0, 8'h48); push_byte(1'b0, 8'h81);
        end
        ss_cyc.delete();
        load_mode = 1'b0; run_en = 1'b1; ui_in = 8'h00;
        repeat (2) @(negedge clk);
        ui_in = 8'h05;
        repeat (3) @(negedge clk);
        chk("scan2_ui_scan", ui_scan, 8'h05);
        chk("scan2_ui_prev", ui_in_prev, 8'h00);
        repeat (2) @(negedge clk);
        chk("scan2_mid_ui_scan", ui_scan, 8'h05);
        chk("scan2_mid_ui_prev", ui_in_prev, 8'h00);
        repeat (2) @(negedge clk);
        chk("scan3_ui_scan", ui_scan, 8'h05);
        chk("scan3_ui_prev", ui_in_prev, 8'h05);
        repeat (4) @(negedge clk);
        load_mode = 1'b1;
        @(negedge clk);
        chk("reload_ready", instr_ready, 0);
        chk("reload_prog_len", prog_len, 0);
        chk("scan_count", ss_cyc.size(), 3);
        if (ss_cyc.size() == 3) begin
            chk("scan_period_1", ss_cyc[1] - ss_cyc[0], 4);
            chk("scan_period_2", ss_cyc[2] - ss_cyc[1], 4);
        end

        // Pause with run_en low after the second byte, then mid-scan abort
        load_byte(8'hAA); load_byte(8'hBB); load_byte(8'hCC);
        push_byte(1'b1, 8'hAA); push_byte(1'b0, 8'hBB); push_byte(1'b0, 8'hCC);
        push_byte(1'b1, 8'hAA);
        load_mode = 1'b0; run_en = 1'b1;
        repeat (3) @(negedge clk);
        run_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("pause_ready", instr_ready, 0);
        end
        chk("pause_pc", pc, 2);
        run_en = 1'b1;
        repeat (3) @(negedge clk);
        load_mode = 1'b1;
        @(negedge clk);
        chk("abort_ready", instr_ready, 0);
        chk("abort_prog_len", prog_len, 0);
        chk("abort_pc", pc, 0);

        // Held strobe writes once; 33 writes overflow a 32-byte store
        load_data = 8'h10; load_strobe = 1'b1;
        repeat (5) @(negedge clk);
        load_strobe = 1'b0;
        @(negedge clk);
        chk("held_strobe_len", prog_len, 1);
        for (int i = 1; i <= 32; i++) load_byte(8'(8'h10 + i));
        chk("full_prog_len", prog_len, 32);
        chk("full_overflow", load_overflow, 1);
        for (int i = 0; i < 32; i++) push_byte(i == 0, 8'(8'h10 + i));
        load_mode = 1'b0; run_en = 1'b1;
        repeat (34) @(negedge clk);
        load_mode = 1'b1;
        @(negedge clk);
        chk("overflow_cleared", load_overflow, 0);
        chk("full_reload_len", prog_len, 0);

        // Empty store returns to IDLE; entry cycle with a strobe edge writes nothing
        load_mode = 1'b0;
        @(negedge clk);
        load_mode = 1'b1; load_strobe = 1'b1; load_data = 8'h77;
        @(negedge clk);
        chk("entry_no_write", prog_len, 0);
        @(negedge clk);
        load_strobe = 1'b0;
        @(negedge clk);
        chk("entry_held_no_write", prog_len, 0);

        // Counter wrap during a running scan does not disturb sequencing
        for (int i = 0; i < 70000 && counter !== 16'hFFF0; i++) @(negedge clk);
        chk("counter_reach", counter, 16'hFFF0);
        load_byte(8'h01); load_byte(8'h02);
        for (int s = 0; s < 4; s++) begin
            push_byte(1'b1, 8'h01); push_byte(1'b0, 8'h02);
        end
        load_mode = 1'b0; run_en = 1'b1;
        wrap_seen = 1'b0;
        for (int k = 0; k < 13; k++) begin
            prev_cnt = counter;
            @(negedge clk);
            if (prev_cnt == 16'hFFFF) begin
                chk("counter_wrap", counter, 0);
                wrap_seen = 1'b1;
            end
        end
        load_mode = 1'b1;
        @(negedge clk);
        chk("wrap_seen", wrap_seen, 1);
        chk("wrap_end_ready", instr_ready, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
